// File: rtl/cix32_fetch_align_ctrl.sv
// Fetch/align controller for the CIX-32 decoder: issues aligned 16-byte fetches,
// buffers bytes in a circular queue and presents a head-aligned 15-byte window.
module cix32_fetch_align_ctrl #(
  parameter int unsigned QUEUE_BYTES = 32,
  parameter logic [31:0] RESET_EIP   = 32'h0000_FFF0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_addr,
  output logic         fetch_req_valid,
  output logic [31:0]  fetch_req_addr,
  input  logic         fetch_req_ready,
  input  logic         fetch_rsp_valid,
  input  logic [127:0] fetch_rsp_data,
  output logic [127:0] dec_bytes,
  output logic [3:0]   dec_valid_bytes,
  output logic         dec_valid,
  input  logic         dec_ready,
  output logic [31:0]  dec_eip,
  input  logic         consume_valid,
  input  logic [3:0]   consume_len,
  output logic         overrun_err
);

  localparam int unsigned AW = $clog2(QUEUE_BYTES);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [QUEUE_BYTES];
  logic [AW-1:0] head_q, head_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    align_q, align_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   eip_q, eip_d;
  logic          ovr_q, ovr_d;
  logic          started_q;

  logic          req_fire;
  logic          append;
  logic [4:0]    app_n;
  logic [3:0]    cons_eff;
  logic [31:0]   post_app;
  logic          unused_dec_ready;

  assign unused_dec_ready = dec_ready;

  assign fetch_req_valid = started_q && (state_q == S_REQ);
  assign fetch_req_addr  = addr_q;
  assign dec_eip         = eip_q;
  assign overrun_err     = ovr_q;
  assign dec_valid       = (count_q >= (AW+1)'(15));
  assign dec_valid_bytes = dec_valid ? 4'd15 : 4'(count_q);

  assign req_fire = fetch_req_valid && fetch_req_ready;
  assign app_n    = 5'd16 - {1'b0, align_q};
  assign append   = (state_q == S_WAIT) && fetch_rsp_valid && !redirect_valid;
  // Room is judged on the post-append count but never credits a same-cycle consume.
  assign post_app = 32'(count_q) + (append ? 32'(app_n) : 32'd0);

  always_comb begin
    state_d  = state_q;
    cons_eff = '0;
    ovr_d    = 1'b0;
    if (consume_valid && (consume_len != '0)) begin
      if (32'(consume_len) > 32'(count_q)) begin
        cons_eff = 4'(count_q);
        ovr_d    = 1'b1;
      end else begin
        cons_eff = consume_len;
      end
    end

    head_d  = head_q + AW'(cons_eff);
    count_d = (AW+1)'(post_app - 32'(cons_eff));
    eip_d   = eip_q + 32'(cons_eff);
    addr_d  = append ? (addr_q + 32'd16) : addr_q;
    align_d = append ? 4'h0 : align_q;

    if (redirect_valid) begin
      head_d  = head_q;
      count_d = '0;
      eip_d   = redirect_addr;
      addr_d  = {redirect_addr[31:4], 4'h0};
      align_d = redirect_addr[3:0];
      ovr_d   = 1'b0;
      case (state_q)
        S_WAIT:  state_d = fetch_rsp_valid ? S_REQ : S_DROP;
        S_REQ:   state_d = req_fire ? S_DROP : S_REQ;
        S_DROP:  state_d = fetch_rsp_valid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ:  if (req_fire) state_d = S_WAIT;
        S_WAIT: begin
          if (fetch_rsp_valid)
            state_d = (post_app + 32'd16 <= QUEUE_BYTES) ? S_REQ : S_HOLD;
        end
        S_HOLD: if (32'(count_q) + 32'd16 <= QUEUE_BYTES) state_d = S_REQ;
        S_DROP: if (fetch_rsp_valid) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      head_q    <= '0;
      count_q   <= '0;
      align_q   <= RESET_EIP[3:0];
      addr_q    <= {RESET_EIP[31:4], 4'h0};
      eip_q     <= RESET_EIP;
      ovr_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      count_q   <= count_d;
      align_q   <= align_d;
      addr_q    <= addr_d;
      eip_q     <= eip_d;
      ovr_q     <= ovr_d;
      started_q <= 1'b1;
    end
  end

  // Response byte k lands at head+count+(k-align_off); bytes below align_off are skipped.
  always_ff @(posedge clk) begin
    if (append) begin
      for (int unsigned k = 0; k < 16; k++) begin
        if (k >= 32'(align_q))
          mem_q[AW'(32'(head_q) + 32'(count_q) + k - 32'(align_q))] <= fetch_rsp_data[k*8 +: 8];
      end
    end
  end

  always_comb begin
    dec_bytes = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      if (i < 32'(dec_valid_bytes))
        dec_bytes[i*8 +: 8] = mem_q[AW'(32'(head_q) + i)];
    end
  end

endmodule

// File: tb/tb_cix32_fetch_align_ctrl.sv
// Self-checking bench for cix32_fetch_align_ctrl: directed scenarios then random traffic,
// compared each cycle against a byte-stream model where queue byte i is mem(eip+i).
module tb_cix32_fetch_align_ctrl;

  localparam int unsigned Q    = 32;
  localparam logic [31:0] REIP = 32'h0000_FFF0;

  logic         clk;
  logic         rst_n;
  logic         redirect_valid;
  logic [31:0]  redirect_addr;
  logic         fetch_req_valid;
  logic [31:0]  fetch_req_addr;
  logic         fetch_req_ready;
  logic         fetch_rsp_valid;
  logic [127:0] fetch_rsp_data;
  logic [127:0] dec_bytes;
  logic [3:0]   dec_valid_bytes;
  logic         dec_valid;
  logic         dec_ready;
  logic [31:0]  dec_eip;
  logic         consume_valid;
  logic [3:0]   consume_len;
  logic         overrun_err;

  cix32_fetch_align_ctrl #(.QUEUE_BYTES(Q), .RESET_EIP(REIP)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .fetch_req_valid(fetch_req_valid), .fetch_req_addr(fetch_req_addr),
    .fetch_req_ready(fetch_req_ready),
    .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_data(fetch_rsp_data),
    .dec_bytes(dec_bytes), .dec_valid_bytes(dec_valid_bytes), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .dec_eip(dec_eip),
    .consume_valid(consume_valid), .consume_len(consume_len),
    .overrun_err(overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] salt;

  // Reference model state
  int          m_size;
  logic [31:0] m_eip;
  logic [31:0] m_addr;
  logic [3:0]  m_align;
  bit          m_inflight, m_drop, m_reqv, m_ovr;

  function automatic logic [7:0] mb(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_size = 0; m_eip = REIP; m_addr = {REIP[31:4], 4'h0}; m_align = REIP[3:0];
    m_inflight = 0; m_drop = 0; m_reqv = 0; m_ovr = 0;
  endtask

  task automatic check_all();
    logic [127:0] eb;
    int nv;
    eb = '0;
    nv = (m_size < 15) ? m_size : 15;
    for (int i = 0; i < nv; i++) eb[i*8 +: 8] = mb(m_eip + 32'(i));
    chk("req_valid", 128'(fetch_req_valid), 128'(m_reqv));
    chk("req_addr", 128'(fetch_req_addr), 128'(m_addr));
    chk("dec_valid", 128'(dec_valid), 128'(m_size >= 15));
    chk("dec_valid_bytes", 128'(dec_valid_bytes), 128'(nv));
    chk("dec_bytes", dec_bytes, eb);
    chk("dec_eip", 128'(dec_eip), 128'(m_eip));
    chk("overrun_err", 128'(overrun_err), 128'(m_ovr));
  endtask

  // One clock: drive inputs, advance the model, then check after the falling edge.
  task automatic tick(input bit rd, input logic [31:0] ra, input bit rdy, input bit rsp,
                      input bit cv, input logic [3:0] cl);
    bit fire, take, n_inf, n_drop;
    int app, room, pre, eff;
    logic [127:0] d;
    if (rsp && m_inflight && !m_drop && !rd) begin
      for (int k = 0; k < 16; k++) d[k*8 +: 8] = mb(m_addr + 32'(k));
    end else begin
      d = {$urandom, $urandom, $urandom, $urandom};
    end
    redirect_valid = rd; redirect_addr = ra; fetch_req_ready = rdy;
    fetch_rsp_valid = rsp; fetch_rsp_data = d; consume_valid = cv; consume_len = cl;

    fire = m_reqv && rdy;
    take = rsp && m_inflight;
    app = 0; n_inf = m_inflight; n_drop = m_drop;
    if (take) begin
      if (!m_drop && !rd) app = 16 - int'(m_align);
      n_inf = 0; n_drop = 0;
    end
    if (fire) begin n_inf = 1; n_drop = rd; end
    else if (rd && n_inf) n_drop = 1;
    m_ovr = 0;
    if (rd) begin
      m_size = 0; m_eip = ra; m_addr = {ra[31:4], 4'h0}; m_align = ra[3:0]; room = 0;
    end else begin
      pre = m_size;
      if (app > 0) begin m_size += app; m_addr += 32'd16; m_align = 4'h0; end
      room = m_size;
      if (cv && cl != 4'd0) begin
        eff = (int'(cl) > pre) ? pre : int'(cl);
        m_ovr = (int'(cl) > pre);
        m_size -= eff; m_eip += 32'(eff);
      end
    end
    m_inflight = n_inf; m_drop = n_drop;
    m_reqv = !n_inf && (room + 16 <= int'(Q));
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    tick(0, 32'h0, 0, 0, 0, 4'd0);
  endtask

  initial begin
    bit rd, rdy, rsp, cv;
    logic [31:0] ra;
    logic [3:0] cl;
    salt = 8'($urandom);
    dec_ready = 1'b1;
    rst_n = 1'b0; redirect_valid = 0; redirect_addr = '0; fetch_req_ready = 0;
    fetch_rsp_valid = 0; fetch_rsp_data = '0; consume_valid = 0; consume_len = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all();
    chk("rst_dec_bytes", dec_bytes, 128'h0);
    rst_n = 1'b1;

    // First request at the reset address, then a full response
    idle();
    chk("first_req_addr", 128'(fetch_req_addr), 128'(32'h0000_FFF0));
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    chk("first_vb", 128'(dec_valid_bytes), 128'(15));
    chk("first_valid", 128'(dec_valid), 128'(1));

    // Unaligned redirect
    tick(1, 32'h0000_1003, 0, 0, 0, 0);
    chk("redir_req_addr", 128'(fetch_req_addr), 128'(32'h0000_1000));
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    chk("redir_vb", 128'(dec_valid_bytes), 128'(13));
    chk("redir_valid", 128'(dec_valid), 128'(0));
    chk("redir_eip", 128'(dec_eip), 128'(32'h0000_1003));
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);          // count 29 -> hold
    chk("hold29", 128'(fetch_req_valid), 128'(0));

    // Fill to 32, then drain in two steps; window crosses index 31->0
    tick(0, 0, 0, 0, 1, 4'd13);      // 16
    idle();
    chk("hold_release", 128'(fetch_req_valid), 128'(1));
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);          // 32
    idle();
    chk("full_hold", 128'(fetch_req_valid), 128'(0));
    tick(0, 0, 0, 0, 1, 4'd5);       // 27
    idle();
    chk("hold27", 128'(fetch_req_valid), 128'(0));
    tick(0, 0, 0, 0, 1, 4'd11);      // 16
    idle();
    chk("room16", 128'(fetch_req_valid), 128'(1));

    // Same-cycle append and consume
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 1, 1, 4'd3);       // 16+16-3 = 29
    tick(0, 0, 0, 0, 1, 4'd15);
    tick(0, 0, 0, 0, 1, 4'd14);
    chk("drained", 128'(dec_valid_bytes), 128'(0));

    // Redirect during an outstanding fetch drops the next response
    for (int n = 0; n < 4 && !m_reqv; n++) idle();
    tick(0, 0, 1, 0, 0, 0);
    tick(1, 32'h2000_0008, 0, 0, 0, 0);
    chk("drop_noreq", 128'(fetch_req_valid), 128'(0));
    tick(0, 0, 0, 1, 0, 0);
    chk("drop_vb", 128'(dec_valid_bytes), 128'(0));
    chk("drop_req", 128'(fetch_req_valid), 128'(1));
    chk("drop_addr", 128'(fetch_req_addr), 128'(32'h2000_0000));

    // Overrun: consume 9 with 6 bytes present
    tick(1, 32'h3000_000A, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    chk("ovr_pre_vb", 128'(dec_valid_bytes), 128'(6));
    tick(0, 0, 0, 0, 1, 4'd9);
    chk("ovr_pulse", 128'(overrun_err), 128'(1));
    chk("ovr_vb", 128'(dec_valid_bytes), 128'(0));
    chk("ovr_eip", 128'(dec_eip), 128'(32'h3000_0010));
    idle();
    chk("ovr_clear", 128'(overrun_err), 128'(0));

    // Reset while a fetch is outstanding; a late response is ignored
    tick(0, 0, 1, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 0, 0, 1, 0, 0);
    chk("late_rsp_vb", 128'(dec_valid_bytes), 128'(0));

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rd  = ($urandom_range(0, 49) == 0);
      ra  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 + 32'($urandom_range(0, 31))) : $urandom;
      rdy = ($urandom_range(0, 9) < 7);
      rsp = m_inflight && ($urandom_range(0, 1) == 1);
      cv  = ($urandom_range(0, 1) == 1);
      cl  = 4'($urandom_range(0, 15));
      tick(rd, ra, rdy, rsp, cv, cl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cix32_fetch_align_ctrl.md
# cix32_fetch_align_ctrl

Fetch/align controller that sequences the CIX-32 x86 decoder. It issues 16-byte aligned fetch requests to the instruction-fetch port and buffers the returned bytes in a circular byte queue. It presents a head-aligned window of up to 15 bytes on the decoder's byte-stream input, and retires bytes as instructions complete decode. It sits between the I-cache/fetch port and `cix32_decoder`, and handles control-flow redirects by flushing the queue and discarding stale fetches.

## Interface
- `QUEUE_BYTES`, 32: byte-queue capacity; power of two, ≥ 32.
- `RESET_EIP`, 32'h0000_FFF0: linear fetch address after reset.

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `redirect_valid`  in  1  flush queue and restart fetch at `redirect_addr`
- `redirect_addr`  in  32  new linear instruction address
- `fetch_req_valid`  out  1  fetch request
- `fetch_req_addr`  out  32  request address; bits [3:0] always 0
- `fetch_req_ready`  in  1  fetch port accepts request
- `fetch_rsp_valid`  in  1  16-byte fetch response
- `fetch_rsp_data`  in  128  response; byte k = `[k*8 +: 8]`
- `dec_bytes`  out  128  window to decoder `bytes_in`; byte i = queue[head+i]
- `dec_valid_bytes`  out  4  min(count, 15)
- `dec_valid`  out  1  to decoder `in_valid`
- `dec_ready`  in  1  from decoder `in_ready`
- `dec_eip`  out  32  linear address of window byte 0
- `consume_valid`  in  1  decoder retired one instruction (`inst_valid & inst_ready`)
- `consume_len`  in  4  retired length, 1..15
- `overrun_err`  out  1  one-cycle pulse on illegal consume

## Operation
- The queue is circular with `head` and `count` (0..QUEUE_BYTES). Indices are taken mod QUEUE_BYTES.
- The FSM has four states:
  - `S_REQ`: drive `fetch_req_valid`. On `fetch_req_ready`, go to `S_WAIT`.
  - `S_WAIT`: wait for `fetch_rsp_valid`. Append the bytes, then go to `S_REQ` if room, else `S_HOLD`.
  - `S_HOLD`: queue lacks room. Go to `S_REQ` when room.
  - `S_DROP`: wait for one stale response, discard it, then go to `S_REQ`.
- Room condition: registered `count + 16 ≤ QUEUE_BYTES`. Same-cycle consume is not credited.
- Only one fetch is outstanding. Responses arrive ≥1 cycle after the request handshake, in order.
- Append: response bytes `align_off`..15 are written at `head+count`. `count += 16-align_off`. `align_off` then clears to 0. `fetch_req_addr += 16`, wrapping mod 2^32.
- Window: `dec_bytes` byte i equals the queue byte for i < min(count,15), else 8'h00. `dec_valid` = (count ≥ 15). All window outputs decode combinationally from registers.
- Consume, when `consume_valid` and `consume_len` ≠ 0:
  - `head += consume_len`, `count -= consume_len`, `dec_eip += consume_len` (mod 2^32).
  - If `consume_len > count`: clamp the consume to `count`, advance `dec_eip` by `count`, pulse `overrun_err`.
  - `consume_len` = 0 is ignored.
- Same-cycle append and consume: new count = count + appended − consumed. Both apply.
- Redirect has priority over append and consume in the same cycle:
  - Set `count` to 0 and `dec_eip` to `redirect_addr`.
  - Set `fetch_req_addr` to {`redirect_addr`[31:4], 4'h0} and `align_off` to `redirect_addr`[3:0].
  - From `S_WAIT`, go to `S_DROP`. A response arriving in the redirect cycle is itself the stale one, so go to `S_REQ` directly.
  - From `S_REQ` with the handshake in the same cycle, the accepted request is stale: go to `S_DROP`.
  - Otherwise go to `S_REQ`.
  - A redirect while in `S_DROP` only updates the addresses.
- `dec_ready` is informational; the window changes only on append, consume or redirect. The decoder latches the window on `dec_valid & dec_ready`.

## Timing
- Reset values:
  - `fetch_req_valid` 0, `fetch_req_addr` {RESET_EIP[31:4],4'h0}
  - `dec_valid` 0, `dec_valid_bytes` 0, `dec_bytes` 0
  - `dec_eip` RESET_EIP, `overrun_err` 0
  - state `S_REQ`, `count` 0, `head` 0, `align_off` RESET_EIP[3:0]
- `fetch_req_valid` rises on the first clk edge after `rst_n` deasserts.
- A response at edge N is visible on the window after edge N.
- Redirect at edge N: `fetch_req_valid` is asserted in cycle N+1 unless the next state is `S_DROP`.
- `fetch_req_valid` stays high until accepted, and `fetch_req_addr` is stable while it is high, except on redirect.
- `rst_n` asserted mid-fetch: everything resets immediately. A response arriving after reset but before a new request is ignored, because `S_REQ` does not sample `fetch_rsp_valid`.

## Test plan
- Reset with RESET_EIP=0xFFF0 → first request 0xFFF0, `align_off` 0. After the response, count=16, `dec_valid`=1, `dec_valid_bytes`=15, byte0=rsp byte0.
- Redirect to 0x1003 → request 0x1000. Response bytes 3..15 are appended, count=13, `dec_valid`=0, `dec_eip`=0x1003. After the next 16 bytes, count=29.
- Queue fill and wrap: count=32 forces `S_HOLD`. Consume 5 → count=27, still held. Consume 11 → count=16, request issued. Consume across index 31→0 returns the correct bytes.
- Same-cycle response plus consume_len=3 with count=16 → count=29.
- Redirect during `S_WAIT` → the next response is dropped (count stays 0), then the request goes to the new address.
- consume_len=9 with count=6 → `overrun_err` pulses, count=0, `dec_eip` +6.
